// File: rtl/req_enc_pkg.sv
// req_enc_pkg: shared widths and types for the 8-to-3 request encoder.
package req_enc_pkg;
  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;
  typedef logic [N_REQ-1:0]  req_vec_t;
  typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/prio_pick8.sv
// prio_pick8: combinational pick of the first set candidate searching upward from i_base with wrap.
module prio_pick8
  import req_enc_pkg::*;
(
  input  logic [N_REQ-1:0]  i_cand,
  input  logic [CODE_W-1:0] i_base,
  output logic [CODE_W-1:0] o_idx,
  output logic              o_found
);
  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  code_t              w_off;
  assign w_dbl   = {i_cand, i_cand} >> i_base;
  assign w_rot   = w_dbl[N_REQ-1:0];
  assign o_found = |i_cand;
  assign o_idx   = i_base + w_off;
  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (w_rot[i]) w_off = code_t'(i);
  end
endmodule

// File: rtl/req_encoder8.sv
// req_encoder8: sticky 8-line request accumulator with a registered valid/ready encoded index.
// Define REQ_ENCODER_RR_EN for round-robin priority; otherwise the lowest index wins.
module req_encoder8
  import req_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  mask,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [N_REQ-1:0]  pending
);
  req_vec_t r_pend;
  code_t    r_code;
  logic     r_valid;
  logic     w_hs, w_load, w_found;
  req_vec_t w_clr, w_pend_nxt, w_cand;
  code_t    w_base, w_idx;
  assign w_hs       = r_valid & ready;
  assign w_load     = ~r_valid | w_hs;
  assign w_clr      = w_hs ? req_vec_t'(1) << r_code : '0;
  // set wins over clear so a re-raised request is served again
  assign w_pend_nxt = (r_pend & ~w_clr) | req;
  assign w_cand     = w_pend_nxt & mask;
`ifdef REQ_ENCODER_RR_EN
  code_t r_ptr;
  assign w_base = w_hs ? r_code + 3'd1 : r_ptr;
  always_ff @(posedge clk)
    if (rst) r_ptr <= '0;
    else if (w_hs) r_ptr <= r_code + 3'd1;
`else
  assign w_base = '0;
`endif
  prio_pick8 u_pick (
    .i_cand (w_cand),
    .i_base (w_base),
    .o_idx  (w_idx),
    .o_found(w_found)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_load) begin
        r_valid <= w_found;
        r_code  <= w_found ? w_idx : '0;
      end
    end
  end
  assign code    = r_code;
  assign valid   = r_valid;
  assign pending = r_pend;
endmodule

// File: tb/tb_req_encoder8.sv
// tb_req_encoder8: scenario tasks plus a handshake scoreboard for req_encoder8 (fixed priority build).
module tb_req_encoder8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] mask = 8'hFF;
  logic [2:0] code;
  logic       valid;
  logic       ready = 1'b0;
  logic [7:0] pending;
  int n_chk = 0;
  int n_fail = 0;
  logic [2:0] sb[$];

  req_encoder8 dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .code(code), .valid(valid), .ready(ready), .pending(pending)
  );

  always #5 clk = ~clk;

  // every handshake the next edge will take is checked against the scoreboard
  always @(negedge clk) begin
    logic [2:0] exp;
    if (!rst && valid && ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected code=%0d expected none", code);
      end else begin
        exp = sb.pop_front();
        if (code !== exp) begin
          n_fail++;
          $display("FAIL sb_code got=%0d exp=%0d", code, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; req = '0; mask = 8'hFF;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (valid !== 1'b0 || code !== 3'd0 || pending !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_idle got v=%b c=%0d p=%h exp v=0 c=0 p=00", valid, code, pending);
      end
    end
  endtask

  task automatic test_sweep();
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req = 8'(1) << k;
      sb.push_back(3'(k));
      tick();
      req = '0;
      n_chk++;
      if (valid !== 1'b1 || code !== 3'(k) || pending !== 8'(1) << k) begin
        n_fail++;
        $display("FAIL sweep_hit k=%0d got v=%b c=%0d p=%h", k, valid, code, pending);
      end
      tick();
      n_chk++;
      if (valid !== 1'b0 || pending !== 8'h00) begin
        n_fail++;
        $display("FAIL sweep_clear k=%0d got v=%b p=%h exp v=0 p=00", k, valid, pending);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_codes[4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    ready = 1'b1;
    req = 8'b1010_0110;
    for (int i = 0; i < 4; i++) sb.push_back(exp_codes[i]);
    tick();
    req = '0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (valid !== 1'b1 || code !== exp_codes[i]) begin
        n_fail++;
        $display("FAIL b2b_code idx=%0d got v=%b c=%0d exp v=1 c=%0d", i, valid, code, exp_codes[i]);
      end
      tick();
    end
    n_chk++;
    if (valid !== 1'b0 || pending !== 8'h00 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_end got v=%b p=%h sb=%0d exp v=0 p=00 sb=0", valid, pending, sb.size());
    end
  endtask

  task automatic test_hold();
    ready = 1'b0;
    req = 8'b0001_1000;
    tick();
    req = '0;
    mask = 8'hF7;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (valid !== 1'b1 || code !== 3'd3 || pending !== 8'h18) begin
        n_fail++;
        $display("FAIL hold_stable cyc=%0d got v=%b c=%0d p=%h exp v=1 c=3 p=18", i, valid, code, pending);
      end
      tick();
    end
    sb.push_back(3'd3);
    sb.push_back(3'd4);
    ready = 1'b1;
    tick();
    n_chk++;
    if (valid !== 1'b1 || code !== 3'd4 || pending !== 8'h10) begin
      n_fail++;
      $display("FAIL hold_next got v=%b c=%0d p=%h exp v=1 c=4 p=10", valid, code, pending);
    end
    tick();
    n_chk++;
    if (valid !== 1'b0 || pending !== 8'h00 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL hold_end got v=%b p=%h sb=%0d exp v=0 p=00 sb=0", valid, pending, sb.size());
    end
    mask = 8'hFF;
  endtask

  task automatic test_collision();
    ready = 1'b1;
    req = 8'b0000_0100;
    sb.push_back(3'd2);
    tick();
    sb.push_back(3'd2);
    tick();
    req = '0;
    n_chk++;
    if (valid !== 1'b1 || code !== 3'd2 || pending !== 8'h04) begin
      n_fail++;
      $display("FAIL collision_set_wins got v=%b c=%0d p=%h exp v=1 c=2 p=04", valid, code, pending);
    end
    tick();
    n_chk++;
    if (valid !== 1'b0 || pending !== 8'h00 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL collision_end got v=%b p=%h sb=%0d exp v=0 p=00 sb=0", valid, pending, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    ready = 1'b0;
    req = 8'hFF;
    tick();
    n_chk++;
    if (valid !== 1'b1 || code !== 3'd0 || pending !== 8'hFF) begin
      n_fail++;
      $display("FAIL midrst_pre got v=%b c=%0d p=%h exp v=1 c=0 p=ff", valid, code, pending);
    end
    rst = 1'b1;
    ready = 1'b1;
    tick();
    n_chk++;
    if (valid !== 1'b0 || code !== 3'd0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_post got v=%b c=%0d p=%h exp v=0 c=0 p=00", valid, code, pending);
    end
    rst = 1'b0;
    req = '0;
    tick();
    n_chk++;
    if (valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_idle got v=%b p=%h exp v=0 p=00", valid, pending);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_back_to_back();
    test_hold();
    test_collision();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
